// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: state encoding, BCD digit
// maxima, nibble positions within the 16-bit mm:ss word, and preset check.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

  // Nibble index of each digit inside {min_tens, min_units, sec_tens, sec_units}
  localparam int NIB_SEC_UNITS = 0;
  localparam int NIB_SEC_TENS  = 1;
  localparam int NIB_MIN_UNITS = 2;
  localparam int NIB_MIN_TENS  = 3;

  // A preset is usable when every digit is decimal and seconds tens is 0..5.
  function automatic logic bcd_preset_valid(input logic [15:0] preset);
    return (preset[NIB_MIN_TENS*4  +: 4] <= BCD_MAX_UNITS) &&
           (preset[NIB_MIN_UNITS*4 +: 4] <= BCD_MAX_UNITS) &&
           (preset[NIB_SEC_TENS*4  +: 4] <= BCD_MAX_TENS)  &&
           (preset[NIB_SEC_UNITS*4 +: 4] <= BCD_MAX_UNITS);
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_bcd_down_digit.sv
// One BCD down-counting digit wrapping 0 -> MAX. Digits chain through
// borrow: a digit steps only when enabled and every lower digit borrows.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX_UNITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       borrow_in,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       borrow_out
);

  logic [3:0] r_value;

  assign value      = r_value;
  assign borrow_out = borrow_in && (r_value == 4'd0);

  // Digit register: reset, preset load, or borrow-driven decrement with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= 4'd0;
    end else if (load) begin
      r_value <= load_val;
    end else if (en && borrow_in) begin
      r_value <= (r_value == 4'd0) ? MAX : r_value - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: mm:ss BCD count, prescaled one-second tick,
// IDLE/RUN/PAUSE/ALARM control with done pulse, alarm timeout and preset error.
//
// Control inputs have no handshake: start, pause and load are plain levels
// sampled on every rising clk edge; a level held for N cycles is N requests.
// Within one cycle load beats pause, and pause beats start.
module countdown_timer_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV    = 100000000,
  parameter int ALARM_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        load,
  input  logic [15:0] data,
  output logic [15:0] digits,
  output logic [1:0]  state,
  output logic        done,
  output logic        alarm,
  output logic        error
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  state_t        r_state;
  logic [PW-1:0] r_prescaler;
  logic [AW-1:0] r_alarm_cnt;
  logic          r_done;
  logic          r_alarm;
  logic          r_error;

  logic          w_tick;
  logic          w_preset_ok;
  logic          w_nonzero;
  logic          w_last_second;
  logic          w_load_digits;
  logic          w_dec;
  logic [4:0]    w_borrow;
  logic [15:0]   w_digits;

  assign w_tick        = (r_prescaler == PRE_LAST);
  assign w_preset_ok   = bcd_preset_valid(data);
  assign w_nonzero     = (w_digits != 16'h0000);
  assign w_last_second = (w_digits == 16'h0001);
  assign w_load_digits = ((r_state == ST_IDLE) || (r_state == ST_PAUSE)) && load && w_preset_ok;
  // A borrow out of the top digit would mean underflow below 00:00; never decrement then.
  assign w_dec         = (r_state == ST_RUN) && !pause && w_tick && !w_borrow[4];
  assign w_borrow[0]   = 1'b1;

  bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_sec_units (
    .clk(clk), .reset(reset), .en(w_dec), .borrow_in(w_borrow[0]),
    .load(w_load_digits), .load_val(data[NIB_SEC_UNITS*4 +: 4]),
    .value(w_digits[NIB_SEC_UNITS*4 +: 4]), .borrow_out(w_borrow[1])
  );

  bcd_down_digit #(.MAX(BCD_MAX_TENS)) u_sec_tens (
    .clk(clk), .reset(reset), .en(w_dec), .borrow_in(w_borrow[1]),
    .load(w_load_digits), .load_val(data[NIB_SEC_TENS*4 +: 4]),
    .value(w_digits[NIB_SEC_TENS*4 +: 4]), .borrow_out(w_borrow[2])
  );

  bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_min_units (
    .clk(clk), .reset(reset), .en(w_dec), .borrow_in(w_borrow[2]),
    .load(w_load_digits), .load_val(data[NIB_MIN_UNITS*4 +: 4]),
    .value(w_digits[NIB_MIN_UNITS*4 +: 4]), .borrow_out(w_borrow[3])
  );

  bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_min_tens (
    .clk(clk), .reset(reset), .en(w_dec), .borrow_in(w_borrow[3]),
    .load(w_load_digits), .load_val(data[NIB_MIN_TENS*4 +: 4]),
    .value(w_digits[NIB_MIN_TENS*4 +: 4]), .borrow_out(w_borrow[4])
  );

  // Control FSM with prescaler, alarm second counter and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prescaler <= '0;
      r_alarm_cnt <= '0;
      r_done      <= 1'b0;
      r_alarm     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (load) begin
            if (w_preset_ok) r_error <= 1'b0;
            else             r_error <= 1'b1;
          end else if (!pause && start && w_nonzero) begin
            r_state     <= ST_RUN;
            r_prescaler <= '0;
          end
        end
        ST_PAUSE: begin
          // Prescaler holds here so a resume continues the interrupted second.
          if (load) begin
            if (w_preset_ok) begin
              r_error <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_error <= 1'b1;
            end
          end else if (!pause && start) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            r_state <= ST_PAUSE;
          end else begin
            r_prescaler <= w_tick ? '0 : r_prescaler + 1'b1;
            if (w_dec && w_last_second) begin
              r_state     <= ST_ALARM;
              r_done      <= 1'b1;
              r_alarm     <= 1'b1;
              r_alarm_cnt <= '0;
            end
          end
        end
        ST_ALARM: begin
          if (start || pause) begin
            r_state     <= ST_IDLE;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
          end else begin
            r_prescaler <= w_tick ? '0 : r_prescaler + 1'b1;
            if (w_tick) begin
              if (r_alarm_cnt == ALARM_LAST) begin
                r_state     <= ST_IDLE;
                r_alarm     <= 1'b0;
                r_alarm_cnt <= '0;
              end else begin
                r_alarm_cnt <= r_alarm_cnt + 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign digits = w_digits;
  assign state  = r_state;
  assign done   = r_done;
  assign alarm  = r_alarm;
  assign error  = r_error;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Self-checking bench for countdown_timer_ctrl: directed scenarios plus
// random stimulus, compared every cycle with a seconds-based reference model.
module tb_countdown_timer_ctrl;

  localparam int TD = 4;
  localparam int AT = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic        pause;
  logic        load;
  logic [15:0] data;
  logic [15:0] digits;
  logic [1:0]  state;
  logic        done;
  logic        alarm;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: count kept as plain seconds
  int   m_st;
  int   m_secs;
  int   m_phase;
  int   m_acnt;
  logic m_err;
  logic m_done;

  logic [20:0] exp_q[$];

  countdown_timer_ctrl #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
    .data(data), .digits(digits), .state(state), .done(done),
    .alarm(alarm), .error(error)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic preset_ok(input logic [15:0] d);
    return (d[15:12] <= 9) && (d[11:8] <= 9) && (d[7:4] <= 5) && (d[3:0] <= 9);
  endfunction

  function automatic int bcd_to_secs(input logic [15:0] d);
    return (int'(d[15:12]) * 10 + int'(d[11:8])) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  function automatic logic [15:0] secs_to_bcd(input int secs);
    int mins, s;
    logic [3:0] a, b, c, e;
    mins = secs / 60;
    s    = secs % 60;
    a = 4'(mins / 10);
    b = 4'(mins % 10);
    c = 4'(s / 10);
    e = 4'(s % 10);
    return {a, b, c, e};
  endfunction

  task automatic model_update();
    m_done = 1'b0;
    if (reset) begin
      m_st = 0; m_secs = 0; m_phase = 0; m_acnt = 0; m_err = 1'b0;
    end else begin
      case (m_st)
        0, 2: begin
          if (load) begin
            if (preset_ok(data)) begin
              m_secs = bcd_to_secs(data);
              m_err  = 1'b0;
              m_st   = 0;
            end else begin
              m_err = 1'b1;
            end
          end else if (!pause && start) begin
            if (m_st == 2) begin
              m_st = 1;
            end else if (m_secs != 0) begin
              m_st = 1;
              m_phase = 0;
            end
          end
        end
        1: begin
          if (pause) begin
            m_st = 2;
          end else if (m_phase == TD - 1) begin
            m_phase = 0;
            m_secs--;
            if (m_secs == 0) begin
              m_st = 3; m_done = 1'b1; m_acnt = 0;
            end
          end else begin
            m_phase++;
          end
        end
        default: begin
          if (start || pause) begin
            m_st = 0; m_acnt = 0;
          end else if (m_phase == TD - 1) begin
            m_phase = 0;
            m_acnt++;
            if (m_acnt == AT) begin
              m_st = 0; m_acnt = 0;
            end
          end else begin
            m_phase++;
          end
        end
      endcase
    end
  endtask

  // one clock: update model from current inputs, then compare after the edge
  task automatic step();
    logic [20:0] e;
    logic [1:0]  st;
    model_update();
    st = 2'(m_st);
    exp_q.push_back({secs_to_bcd(m_secs), st, m_done, logic'(m_st == 3), m_err});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("digits", digits, e[20:5]);
    check_eq("state", {14'd0, state}, {14'd0, e[4:3]});
    check_eq("done", {15'd0, done}, {15'd0, e[2]});
    check_eq("alarm", {15'd0, alarm}, {15'd0, e[1]});
    check_eq("error", {15'd0, error}, {15'd0, e[0]});
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic idle_inputs();
    start = 1'b0; pause = 1'b0; load = 1'b0; data = 16'h0000; reset = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] d);
    load = 1'b1; data = d; step(); load = 1'b0; data = 16'h0000;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1; step(); pause = 1'b0;
  endtask

  initial begin
    idle_inputs();
    m_st = 0; m_secs = 0; m_phase = 0; m_acnt = 0; m_err = 1'b0; m_done = 1'b0;

    // reset state
    reset = 1'b1; step(); step(); reset = 1'b0;
    check_eq("rst_digits", digits, 16'h0000);
    check_eq("rst_state", {14'd0, state}, 16'd0);

    // start at 00:00 is ignored
    do_start();
    check_eq("start_zero_ignored", {14'd0, state}, 16'd0);

    // 00:12 counts to 00:11 four cycles after entering RUN, then 00:10
    do_load(16'h0012);
    do_start();
    cyc(3);
    check_eq("pre_first_tick", digits, 16'h0012);
    step();
    check_eq("first_tick_0011", digits, 16'h0011);
    cyc(4);
    check_eq("second_tick_0010", digits, 16'h0010);
    // load ignored while running
    do_load(16'h0555);
    check_eq("load_in_run", {14'd0, state}, 16'd1);

    // borrow through two digits and through all three
    do_reset();
    do_load(16'h0100);
    do_start();
    cyc(4);
    check_eq("borrow_0059", digits, 16'h0059);
    do_reset();
    do_load(16'h1000);
    do_start();
    cyc(4);
    check_eq("borrow_0959", digits, 16'h0959);

    // reaching zero: done pulse, ALARM, timeout after AT ticks
    do_reset();
    do_load(16'h0001);
    do_start();
    cyc(3);
    check_eq("no_done_early", {15'd0, done}, 16'd0);
    step();
    check_eq("zero_digits", digits, 16'h0000);
    check_eq("done_pulse", {15'd0, done}, 16'd1);
    check_eq("alarm_state", {14'd0, state}, 16'd3);
    step();
    check_eq("done_single", {15'd0, done}, 16'd0);
    cyc(AT * TD - 2);
    check_eq("alarm_held", {15'd0, alarm}, 16'd1);
    step();
    check_eq("alarm_timeout", {14'd0, state}, 16'd0);

    // invalid preset sets error, valid preset clears it
    do_load(16'h0060);
    check_eq("err_set", {15'd0, error}, 16'd1);
    check_eq("err_digits_kept", digits, 16'h0000);
    do_load(16'h0030);
    check_eq("err_clear", {15'd0, error}, 16'd0);
    check_eq("load_0030", digits, 16'h0030);

    // pause mid-second, resume continues from held prescaler
    do_start();
    cyc(2);
    pause = 1'b1; cyc(10); pause = 1'b0;
    check_eq("pause_state", {14'd0, state}, 16'd2);
    check_eq("pause_no_dec", digits, 16'h0030);
    do_start();
    step();
    check_eq("resume_not_yet", digits, 16'h0030);
    step();
    check_eq("resume_tick_0029", digits, 16'h0029);

    // alarm acknowledge by pause
    do_reset();
    do_load(16'h0001);
    do_start();
    cyc(4);
    do_pause();
    check_eq("alarm_ack", {14'd0, state}, 16'd0);

    // reset in ALARM beats start and load
    do_load(16'h0001);
    do_start();
    cyc(4);
    reset = 1'b1; start = 1'b1; load = 1'b1; data = 16'h0005;
    step();
    idle_inputs();
    check_eq("rst_alarm_digits", digits, 16'h0000);
    check_eq("rst_alarm_state", {14'd0, state}, 16'd0);
    check_eq("rst_alarm_flags", {13'd0, done, alarm, error}, 16'd0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 19) == 0);
      load  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 0)
        data = 16'($urandom);
      else
        data = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      step();
    end
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
